uart_loopback_ctrl: RTL
=======================

UART_LOOPBACK_CTRL -- requirements
Module: uart_loopback_ctrl

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 8, width of a UART data byte.
REQ-002 SHALL have parameter P_FIFO_DEPTH, default 16, FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter P_AFULL_LEVEL, default 12, almost-full threshold, 1 to P_FIFO_DEPTH.
REQ-004 SHALL have parameter P_CNT_WIDTH, default 16, drop-counter width.
REQ-005 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port i_rx_data  input  P_DATA_WIDTH  received byte from the UART drive.
REQ-008 SHALL have port i_rx_valid  input  1  one-cycle strobe, i_rx_data valid.
REQ-009 SHALL have port o_tx_data  output  P_DATA_WIDTH  byte to the UART drive transmitter.
REQ-010 SHALL have port o_tx_valid  output  1  o_tx_data valid.
REQ-011 SHALL have port i_tx_ready  input  1  transmitter can accept a byte.
REQ-012 SHALL have port i_tx_en  input  1  1 = forward bytes, 0 = pause (buffer only).
REQ-013 SHALL have port i_clr_ovf  input  1  one-cycle clear of the overflow flag and drop counter.
REQ-014 SHALL have port o_level  output  clog2(P_FIFO_DEPTH)+1  FIFO entries held, output register excluded.
REQ-015 SHALL have port o_afull  output  1  high while o_level >= P_AFULL_LEVEL.
REQ-016 SHALL have port o_overflow  output  1  sticky flag: a byte was dropped.
REQ-017 SHALL have port o_drop_cnt  output  P_CNT_WIDTH  number of dropped bytes, saturating.

Function
REQ-018 SHALL store each byte with i_rx_valid=1 into a circular FIFO, using read/write pointers with one extra wrap bit; full when the pointers differ only in the MSB, empty when equal.
REQ-019 SHALL drop a byte that arrives while the FIFO is full, even if a pop happens in the same cycle; o_level SHALL NOT change because of a dropped byte.
REQ-020 SHALL set o_overflow and increment o_drop_cnt on each drop; o_drop_cnt SHALL saturate at all-ones.
REQ-021 SHALL clear o_overflow and set o_drop_cnt to 0 on i_clr_ovf; if a drop happens in the same cycle, o_overflow=1 and o_drop_cnt=1 after the edge.
REQ-022 SHALL hold an output register (o_tx_data, o_tx_valid); a transfer completes on any edge where o_tx_valid=1 and i_tx_ready=1.
REQ-023 SHALL pop the FIFO head into the output register when the FIFO is not empty, i_tx_en=1, and either o_tx_valid=0 or a transfer completes in that cycle; this gives back-to-back bytes with no idle cycle.
REQ-024 SHALL clear o_tx_valid after a transfer if no pop occurs in that cycle.
REQ-025 SHALL keep o_tx_valid high and o_tx_data stable from assertion until the transfer; i_tx_en=0 SHALL NOT withdraw a byte already presented.
REQ-026 SHALL assert o_tx_valid in cycle c+2 for an i_rx_valid pulse in cycle c, when the FIFO and output register are empty and i_tx_en=1.
REQ-027 SHALL update o_level correctly on a simultaneous push and pop (unchanged when not full); o_level and o_afull SHALL be registered.
REQ-028 SHALL output bytes in arrival order across pointer wrap-around, with no loss or duplication.
REQ-029 SHALL produce exactly one transfer per stored byte; a ready signal that stays high for many cycles SHALL NOT cause a byte to repeat.

Reset
REQ-030 SHALL, while i_rst_n=0, asynchronously force: pointers 0, o_level 0, o_afull 0, o_tx_valid 0, o_tx_data 0, o_overflow 0, o_drop_cnt 0.
REQ-031 SHALL discard FIFO contents and any presented byte on reset mid-operation; the first byte after release SHALL be the first byte received after release.

Verification
REQ-032 SHALL pass: single byte 0xA5, i_tx_ready=1, i_tx_en=1 -> o_tx_valid high exactly one cycle, at c+2, o_tx_data=0xA5.
REQ-033 SHALL pass: 20 bytes 0x00..0x13 with i_tx_en=0 (depth 16) -> o_level=16, o_afull=1, o_overflow=1, o_drop_cnt=4; then i_tx_en=1 -> 0x00..0x0F out in order.
REQ-034 SHALL pass: i_tx_ready held high, FIFO holding 5 bytes -> 5 consecutive transfer cycles, then o_tx_valid=0, o_level=0.
REQ-035 SHALL pass: i_tx_ready low for 10 cycles while o_tx_valid=1 -> o_tx_data unchanged; a later ready pulse completes exactly one transfer.
REQ-036 SHALL pass: i_clr_ovf in the same cycle as a drop -> o_overflow=1, o_drop_cnt=1.
REQ-037 SHALL pass: i_rst_n low with 7 bytes stored and o_tx_valid=1 -> all outputs at reset values immediately, no stale byte after release.

Source files
------------

// File: rtl/uart_loopback_ctrl.sv
// UART loopback buffer: received bytes are queued in a circular FIFO and forwarded
// to the transmitter through a ready/valid output register, with overflow accounting.
module uart_loopback_ctrl #(
    parameter int P_DATA_WIDTH  = 8,
    parameter int P_FIFO_DEPTH  = 16,
    parameter int P_AFULL_LEVEL = 12,
    parameter int P_CNT_WIDTH   = 16
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [P_DATA_WIDTH-1:0]         i_rx_data,
    input  logic                            i_rx_valid,
    output logic [P_DATA_WIDTH-1:0]         o_tx_data,
    output logic                            o_tx_valid,
    input  logic                            i_tx_ready,
    input  logic                            i_tx_en,
    input  logic                            i_clr_ovf,
    output logic [$clog2(P_FIFO_DEPTH):0]   o_level,
    output logic                            o_afull,
    output logic                            o_overflow,
    output logic [P_CNT_WIDTH-1:0]          o_drop_cnt
);

    localparam int ADDR_W = $clog2(P_FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [PTR_W-1:0]       PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]       FULL_XOR  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PTR_W-1:0]       AFULL_LVL = PTR_W'(P_AFULL_LEVEL);
    localparam logic [P_CNT_WIDTH-1:0] CNT_ONE   = P_CNT_WIDTH'(1);
    localparam logic [P_CNT_WIDTH-1:0] CNT_ZERO  = {P_CNT_WIDTH{1'b0}};
    localparam logic [P_CNT_WIDTH-1:0] CNT_MAX   = {P_CNT_WIDTH{1'b1}};

    logic [P_DATA_WIDTH-1:0] mem_q [P_FIFO_DEPTH];

    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]        level_q, level_d;
    logic                    afull_q, afull_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [P_DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                    ovf_q, ovf_d;
    logic [P_CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic full_s, empty_s, push_s, drop_s, pop_s, xfer_s;

    // Handshake decode; a full FIFO drops the incoming byte even when a pop frees a slot.
    always_comb begin
        full_s  = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
        empty_s = (wr_ptr_q == rd_ptr_q);
        xfer_s  = tx_valid_q && i_tx_ready;
        push_s  = i_rx_valid && !full_s;
        drop_s  = i_rx_valid && full_s;
        pop_s   = !empty_s && i_tx_en && (!tx_valid_q || xfer_s);
    end

    // Next-state for pointers, level/almost-full, output register and drop accounting.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            tx_valid_d = 1'b1;
            tx_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
        end else if (xfer_s) begin
            rd_ptr_d   = rd_ptr_q;
            tx_valid_d = 1'b0;
        end else begin
            rd_ptr_d   = rd_ptr_q;
        end

        level_d = wr_ptr_d - rd_ptr_d;
        afull_d = (level_d >= AFULL_LVL);

        // A clear coinciding with a drop leaves exactly that one drop recorded.
        if (i_clr_ovf) begin
            ovf_d = drop_s;
            cnt_d = drop_s ? CNT_ONE : CNT_ZERO;
        end else if (drop_s) begin
            ovf_d = 1'b1;
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        end else begin
            ovf_d = ovf_q;
            cnt_d = cnt_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= {PTR_W{1'b0}};
            afull_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= {P_DATA_WIDTH{1'b0}};
            ovf_q      <= 1'b0;
            cnt_q      <= CNT_ZERO;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            afull_q    <= afull_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage array; contents are don't-care until written, so it carries no reset.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_rx_data;
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;
    assign o_level    = level_q;
    assign o_afull    = afull_q;
    assign o_overflow = ovf_q;
    assign o_drop_cnt = cnt_q;

endmodule
